ts_os_rx_decoder: RTL and testbench
===================================

TS_OS_RX_DECODER -- requirements
Module: ts_os_rx_decoder

Interface
REQ-001 The block SHALL have parameter CONSEC_TARGET, default 8, giving the number of consecutive identical TS sets that raises ts_consec_hit.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port rx_valid, input, 1 bit: the decoded symbol is valid this cycle.
REQ-005 The block SHALL have port rx_data, input, 8 bits: decoded 8b symbol.
REQ-006 The block SHALL have port rx_is_k, input, 1 bit: rx_data is a K symbol.
REQ-007 The block SHALL have port cnt_clear, input, 1 bit: LTSSM substate change; clears the consecutive count.
REQ-008 The block SHALL have port ts_valid, output, 1 bit: one-cycle pulse when a complete, well-formed TS is accepted.
REQ-009 The block SHALL have port ts_type, output, 1 bit: 0 = TS1, 1 = TS2.
REQ-010 The block SHALL have ports link_num, lane_num, n_fts, rate_id, train_ctrl, outputs, 8 bits each: TS symbols 1-5.
REQ-011 The block SHALL have ports link_pad and lane_pad, outputs, 1 bit each: symbol 1 or symbol 2 was K23.7 (PAD).
REQ-012 The block SHALL have port consec_cnt, output, 4 bits: count of consecutive identical TS sets.
REQ-013 The block SHALL have port ts_consec_hit, output, 1 bit: level, consec_cnt >= CONSEC_TARGET.
REQ-014 The block SHALL have port ts_err, output, 1 bit: one-cycle pulse on malformed-set abort.

Function
REQ-015 The block SHALL consume symbols only on cycles with rx_valid=1; rx_valid=0 stalls parsing without error.
REQ-016 The FSM SHALL have states IDLE, HDR and IDENT.
- IDLE: K28.5 (COM, 0xBC, is_k=1) -> HDR with idx=1.
- HDR: captures symbols 1-5; -> IDENT after idx=5.
- IDENT: checks symbols 6-15.
REQ-017 In HDR, symbols 1-2 SHALL be data or K23.7 (0xF7); any other K symbol, including COM, SHALL abort.
REQ-018 In HDR, symbols 3-5 SHALL be data, else abort.
REQ-019 In IDENT, symbol 6 SHALL set the type: D10.2 (0x4A) = TS1, D5.2 (0x45) = TS2; any other value SHALL abort.
REQ-020 In IDENT, symbols 7-15 SHALL equal symbol 6 as a data symbol, else abort.
REQ-021 On abort, ts_err SHALL pulse the next cycle, the FSM SHALL go to IDLE, and consec_cnt SHALL clear to 0.
REQ-022 A COM received in HDR or IDENT SHALL abort the current set and also start a new set (next state HDR, idx=1).
REQ-023 ts_valid SHALL pulse exactly one cycle after symbol 15 is accepted; field outputs SHALL update on the same edge and hold until the next ts_valid.
REQ-024 On accept, if the type and symbols 1-5 equal the previously accepted TS and consec_cnt>0, consec_cnt SHALL increment, saturating at 15; otherwise consec_cnt SHALL load 1.
REQ-025 cnt_clear SHALL zero consec_cnt; if it coincides with an accept, the result SHALL be 1 (a new run starts).
REQ-026 ts_consec_hit SHALL be combinational from consec_cnt.
REQ-027 A COM accepted on the same cycle that completes symbol 15 is not possible by construction; a COM immediately following symbol 15 SHALL be accepted with no idle gap.

Reset
REQ-028 While rst_n=0 at a clk edge:
- The FSM SHALL go to IDLE and idx to 0.
- ts_valid, ts_err, ts_type, link_pad, lane_pad and consec_cnt SHALL be 0.
- All 8-bit field outputs SHALL be 0x00.
- The stored previous-TS copy SHALL be invalidated.
REQ-029 Reset asserted mid-set SHALL discard the partial set with no ts_err pulse.

Structure
REQ-030 Symbol constants (COM, PAD, TS1_ID, TS2_ID), the ts_type enum and the FSM state enum SHALL reside in a shared package next to the LTSSM package.
REQ-031 A packed struct of the TS fields SHALL be defined in that package and used for the previous-TS compare.
REQ-032 No sub-module is required; the block SHALL be a single module.

Verification
REQ-033 The bench SHALL send 8 back-to-back TS1 sets (link PAD, lane PAD, n_fts=0x20, rate=0x02, ctrl=0x00). Required: 8 ts_valid pulses, consec_cnt=8, ts_consec_hit=1, link_pad=lane_pad=1.
REQ-034 The bench SHALL send 3 TS1 sets, then a TS1 with lane_num=0x01. Required: consec_cnt goes 1, 2, 3, then 1.
REQ-035 The bench SHALL send a TS2 with symbol 10 = 0x4A. Required: ts_err pulse, no ts_valid, consec_cnt=0.
REQ-036 The bench SHALL inject a COM at symbol 4, followed by a full TS2. Required: ts_err pulse, then ts_valid with ts_type=1 and consec_cnt=1.
REQ-037 The bench SHALL deassert rx_valid randomly during 5 identical TS1 sets. Required: 5 ts_valid pulses, consec_cnt=5, no ts_err.
REQ-038 The bench SHALL assert cnt_clear on a ts_valid cycle after 4 sets, and assert rst_n=0 mid-set. Required: consec_cnt=1 after the clear; all outputs 0 after the reset, with no ts_err.

Source files
------------

// File: rtl/ts_os_rx_decoder_pkg.sv
// ts_os_rx_decoder_pkg: shared symbol constants, TS type / FSM state enums and
// the packed TS field record used by the ordered-set receive decoder.
package ts_os_rx_decoder_pkg;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef enum logic {
        TS1 = 1'b0,
        TS2 = 1'b1
    } ts_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        IDENT = 2'd2
    } rx_state_e;

    // Everything that must match for two TS sets to count as identical.
    typedef struct packed {
        ts_type_e   ts_type;
        logic       link_pad;
        logic       lane_pad;
        logic [7:0] link_num;
        logic [7:0] lane_num;
        logic [7:0] n_fts;
        logic [7:0] rate_id;
        logic [7:0] train_ctrl;
    } ts_fields_t;

endpackage

// File: rtl/ts_os_rx_decoder.sv
// ts_os_rx_decoder: parses TS1/TS2 ordered sets from a decoded symbol stream
// and counts consecutive identical sets.
//   clk, rst_n (sync, active-low)
//   rx_valid/rx_data/rx_is_k : decoded symbol input, consumed when rx_valid=1
//   cnt_clear                : zeroes the consecutive count (LTSSM substate change)
//   ts_valid / ts_err        : one-cycle pulses for accepted / aborted sets
//   ts_type, link_num, lane_num, n_fts, rate_id, train_ctrl, link_pad, lane_pad
//                            : fields of the last accepted set
//   consec_cnt, ts_consec_hit: run length of identical sets and its threshold flag
module ts_os_rx_decoder
    import ts_os_rx_decoder_pkg::*;
#(
    parameter int unsigned CONSEC_TARGET = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_is_k,
    input  logic       cnt_clear,
    output logic       ts_valid,
    output logic       ts_type,
    output logic [7:0] link_num,
    output logic [7:0] lane_num,
    output logic [7:0] n_fts,
    output logic [7:0] rate_id,
    output logic [7:0] train_ctrl,
    output logic       link_pad,
    output logic       lane_pad,
    output logic [3:0] consec_cnt,
    output logic       ts_consec_hit,
    output logic       ts_err
);

    rx_state_e  r_state, w_state_nxt;
    logic [3:0] r_idx, w_idx_nxt;
    ts_fields_t r_cur, w_cur_nxt;
    ts_fields_t r_out;
    logic       r_valid, r_err;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       w_abort, w_accept, w_ok, w_com, w_pad, w_match;
    logic [7:0] w_id;

    assign w_com = rx_is_k && rx_data == COM;
    assign w_pad = rx_is_k && rx_data == PAD;
    assign w_id  = (r_cur.ts_type == TS2) ? TS2_ID : TS1_ID;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cur_nxt   = r_cur;
        w_abort     = 1'b0;
        w_accept    = 1'b0;
        w_ok        = 1'b0;
        if (rx_valid) begin
            // A COM always starts a fresh set, aborting whatever was in flight.
            if (w_com) begin
                w_abort     = (r_state != IDLE);
                w_state_nxt = HDR;
                w_idx_nxt   = 4'd1;
            end else if (r_state == HDR) begin
                w_ok = !rx_is_k || (w_pad && r_idx <= 4'd2);
                if (!w_ok) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 4'd0;
                end else begin
                    case (r_idx)
                        4'd1: begin
                            w_cur_nxt.link_num = rx_data;
                            w_cur_nxt.link_pad = w_pad;
                        end
                        4'd2: begin
                            w_cur_nxt.lane_num = rx_data;
                            w_cur_nxt.lane_pad = w_pad;
                        end
                        4'd3:    w_cur_nxt.n_fts      = rx_data;
                        4'd4:    w_cur_nxt.rate_id    = rx_data;
                        default: w_cur_nxt.train_ctrl = rx_data;
                    endcase
                    w_state_nxt = (r_idx == 4'd5) ? IDENT : HDR;
                    w_idx_nxt   = r_idx + 4'd1;
                end
            end else if (r_state == IDENT) begin
                // Symbol 6 picks the identifier; 7-15 must repeat it.
                w_ok = !rx_is_k && ((r_idx == 4'd6) ? (rx_data == TS1_ID || rx_data == TS2_ID)
                                                    : (rx_data == w_id));
                if (!w_ok) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 4'd0;
                end else begin
                    if (r_idx == 4'd6)
                        w_cur_nxt.ts_type = (rx_data == TS2_ID) ? TS2 : TS1;
                    w_accept    = (r_idx == 4'd15);
                    w_state_nxt = w_accept ? IDLE : IDENT;
                    w_idx_nxt   = w_accept ? 4'd0 : r_idx + 4'd1;
                end
            end
        end
    end

    // r_out doubles as the previous-TS copy; a zero count marks it invalid.
    assign w_match   = !cnt_clear && r_cnt != 4'd0 && r_cur == r_out;
    assign w_cnt_nxt = w_abort  ? 4'd0 :
                       w_accept ? (w_match ? ((r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1) : 4'd1) :
                       cnt_clear ? 4'd0 : r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            r_cur   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cur   <= w_cur_nxt;
            r_valid <= w_accept;
            r_err   <= w_abort;
            r_cnt   <= w_cnt_nxt;
            if (w_accept)
                r_out <= r_cur;
        end
    end

    assign ts_valid      = r_valid;
    assign ts_err        = r_err;
    assign ts_type       = r_out.ts_type;
    assign link_pad      = r_out.link_pad;
    assign lane_pad      = r_out.lane_pad;
    assign link_num      = r_out.link_num;
    assign lane_num      = r_out.lane_num;
    assign n_fts         = r_out.n_fts;
    assign rate_id       = r_out.rate_id;
    assign train_ctrl    = r_out.train_ctrl;
    assign consec_cnt    = r_cnt;
    assign ts_consec_hit = 32'(r_cnt) >= CONSEC_TARGET;

endmodule

// File: tb/tb_ts_os_rx_decoder.sv
// tb_ts_os_rx_decoder: directed and randomized TS streams checked against a
// set-level scoreboard model of the decoder.
module tb_ts_os_rx_decoder;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] ID1   = 8'h4A;
    localparam logic [7:0] ID2   = 8'h45;

    typedef struct packed {
        logic       typ;
        logic       lpad;
        logic       npad;
        logic [7:0] link;
        logic [7:0] lane;
        logic [7:0] nfts;
        logic [7:0] rate;
        logic [7:0] ctrl;
    } tsf_t;

    typedef struct packed {
        logic       err;
        tsf_t       f;
        logic [3:0] cnt;
        logic       hit;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_is_k = 1'b0;
    logic       cnt_clear = 1'b0;
    logic       ts_valid, ts_type, link_pad, lane_pad, ts_consec_hit, ts_err;
    logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctrl;
    logic [3:0] consec_cnt;

    int   tests = 0;
    int   fails = 0;
    ev_t  got_q[$];
    ev_t  exp_q[$];
    tsf_t m_prev = '0;
    int   m_cnt = 0;

    ts_os_rx_decoder #(.CONSEC_TARGET(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_is_k(rx_is_k), .cnt_clear(cnt_clear), .ts_valid(ts_valid),
        .ts_type(ts_type), .link_num(link_num), .lane_num(lane_num),
        .n_fts(n_fts), .rate_id(rate_id), .train_ctrl(train_ctrl),
        .link_pad(link_pad), .lane_pad(lane_pad), .consec_cnt(consec_cnt),
        .ts_consec_hit(ts_consec_hit), .ts_err(ts_err)
    );

    always #5 clk = ~clk;

    function automatic tsf_t out_f();
        return '{ts_type, link_pad, lane_pad, link_num, lane_num, n_fts, rate_id, train_ctrl};
    endfunction

    always @(negedge clk) begin
        if (ts_valid === 1'b1) got_q.push_back('{1'b0, out_f(), consec_cnt, ts_consec_hit});
        if (ts_err === 1'b1)   got_q.push_back('{1'b1, out_f(), consec_cnt, ts_consec_hit});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic tsf_t mk(bit typ, bit lp, bit np, logic [7:0] li, logic [7:0] la,
                                logic [7:0] nf, logic [7:0] ra, logic [7:0] ct);
        return '{typ, lp, np, lp ? K_PAD : li, np ? K_PAD : la, nf, ra, ct};
    endfunction

    function automatic tsf_t rand_f();
        return mk(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom));
    endfunction

    function automatic logic [8:0] sym(tsf_t f, int i);
        case (i)
            0:       return {1'b1, K_COM};
            1:       return {f.lpad, f.link};
            2:       return {f.npad, f.lane};
            3:       return {1'b0, f.nfts};
            4:       return {1'b0, f.rate};
            5:       return {1'b0, f.ctrl};
            default: return {1'b0, f.typ ? ID2 : ID1};
        endcase
    endfunction

    function automatic void model_accept(tsf_t f, bit clr);
        m_cnt  = (!clr && m_cnt > 0 && f == m_prev) ? ((m_cnt == 15) ? 15 : m_cnt + 1) : 1;
        m_prev = f;
        exp_q.push_back('{1'b0, f, 4'(m_cnt), m_cnt >= 8});
    endfunction

    function automatic void model_abort();
        m_cnt = 0;
        exp_q.push_back('{1'b1, m_prev, 4'd0, 1'b0});
    endfunction

    task automatic put(input logic [8:0] s, input int gap, input bit clr);
        while (int'($urandom_range(99)) < gap) begin
            @(negedge clk);
            rx_valid = 1'b0; cnt_clear = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1; rx_is_k = s[8]; rx_data = s[7:0]; cnt_clear = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0; cnt_clear = 1'b0;
        end
    endtask

    task automatic send_from(input tsf_t f, input int first, input int gap, input bit clr);
        for (int i = first; i < 16; i++) put(sym(f, i), gap, clr && i == 15);
        model_accept(f, clr);
    endtask

    task automatic send_set(input tsf_t f, input int gap, input bit clr);
        send_from(f, 0, gap, clr);
    endtask

    task automatic send_bad(input tsf_t f, input int pos, input logic [8:0] bad, input int gap);
        for (int i = 0; i < pos; i++) put(sym(f, i), gap, 1'b0);
        put(bad, gap, 1'b0);
        model_abort();
    endtask

    task automatic check_all(input string tag);
        int n;
        idle(3);
        chk({tag, "_evcount"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_ev%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, "_fields"}, 64'(out_f()), 64'(m_prev));
        chk({tag, "_cnt"}, 64'(consec_cnt), 64'(m_cnt));
        chk({tag, "_hit"}, 64'(ts_consec_hit), 64'(m_cnt >= 8));
        chk({tag, "_pulses_idle"}, 64'({ts_valid, ts_err}), 64'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tsf_t fa, fb, fc, f, prev_good;
        logic [8:0] bad;
        logic [7:0] d;
        int pos;
        idle(3);
        chk("reset_outputs", 64'({out_f(), consec_cnt, ts_consec_hit, ts_valid, ts_err}), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 8 back-to-back PAD/PAD TS1 sets reach the threshold, then saturate at 15
        fa = mk(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h20, 8'h02, 8'h00);
        for (int i = 0; i < 8; i++) send_set(fa, 0, 1'b0);
        check_all("b2b8");
        chk("b2b8_pads", 64'({link_pad, lane_pad}), 64'd3);
        for (int i = 0; i < 9; i++) send_set(fa, 0, 1'b0);
        check_all("saturate");

        // Three identical sets then a lane change restarts the run
        fb = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h20, 8'h02, 8'h00);
        fc = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h20, 8'h02, 8'h00);
        for (int i = 0; i < 3; i++) send_set(fb, 0, 1'b0);
        send_set(fc, 0, 1'b0);
        check_all("lane_change");

        // TS2 with a TS1 identifier at symbol 10
        f = mk(1'b1, 1'b0, 1'b0, 8'h05, 8'h03, 8'h40, 8'h06, 8'h01);
        send_bad(f, 10, {1'b0, ID1}, 0);
        check_all("ts2_bad_id");

        // COM at symbol 4 aborts and becomes the start of a full TS2
        send_bad(f, 4, {1'b1, K_COM}, 0);
        send_from(f, 1, 0, 1'b0);
        check_all("com_restart");

        // Random rx_valid gaps during 5 identical TS1 sets
        for (int i = 0; i < 5; i++) send_set(fb, 30, 1'b0);
        check_all("gaps");

        // cnt_clear coinciding with an accept, then a standalone clear
        for (int i = 0; i < 4; i++) send_set(fb, 0, 1'b0);
        send_set(fb, 0, 1'b1);
        check_all("clear_on_accept");
        @(negedge clk);
        rx_valid = 1'b0; cnt_clear = 1'b1;
        m_cnt = 0;
        check_all("clear_idle");
        send_set(fb, 0, 1'b0);
        check_all("after_clear");

        // Reset mid-set discards the partial set silently
        for (int i = 0; i < 8; i++) put(sym(fb, i), 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b0;
        idle(2);
        m_prev = '0;
        m_cnt = 0;
        chk("midreset_outputs", 64'({out_f(), consec_cnt, ts_consec_hit, ts_valid, ts_err}), 64'd0);
        rst_n = 1'b1;
        check_all("midreset");
        send_set(fb, 0, 1'b0);
        check_all("post_reset");

        // Randomized mix of good, repeated and malformed sets
        prev_good = fb;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(9) < 7) begin
                f = ($urandom_range(1) == 1) ? prev_good : rand_f();
                send_set(f, $urandom_range(25), 1'($urandom_range(15) == 0));
                prev_good = f;
            end else begin
                f = rand_f();
                pos = $urandom_range(1, 15);
                d = 8'($urandom);
                if ($urandom_range(3) == 0) bad = {1'b1, K_COM};
                else if (pos <= 2) bad = {1'b1, 8'h1C};
                else if (pos <= 5) bad = {1'b1, K_PAD};
                else if (pos == 6) bad = {1'b0, (d == ID1 || d == ID2) ? 8'h00 : d};
                else bad = $urandom_range(1) ? {1'b1, sym(f, 6) & 9'hFF} : {1'b0, f.typ ? ID1 : ID2};
                send_bad(f, pos, bad, $urandom_range(25));
                if (bad == {1'b1, K_COM}) begin
                    send_from(prev_good, 1, 0, 1'b0);
                end
            end
            if (it % 10 == 9) check_all($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
